// File: rtl/regfile_mbist_ctrl.sv
// regfile_mbist_ctrl: March C- BIST sequencer for the register file 1RW test port.
// Drives bist/csn/wen/a/d, compares read data one cycle later, reports pass/fail and error count.
module regfile_mbist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [7:0]            err_cnt_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((2 ** (ADDR_WIDTH - 1)) - 2);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [2:0] elem, elem_n, pelem;
  logic ph, ph_n, pv, two_op, down, last_ph, end_addr, final_op, rd_n, miscmp;
  logic [ADDR_WIDTH-1:0] addr_n, paddr;
  logic [DATA_WIDTH-1:0] pexp;
  // a_t_o/elem/ph describe the op on the port now; the *_n values are the op for next cycle
  always_comb begin
    two_op = elem != 3'd0 && elem != 3'd5;
    down = elem == 3'd3 || elem == 3'd4;
    last_ph = !two_op || ph;
    end_addr = down ? a_t_o == '0 : a_t_o == LAST;
    final_op = elem == 3'd5 && end_addr;
    elem_n = last_ph && end_addr ? elem + 3'd1 : elem;
    ph_n = !last_ph;
    addr_n = !last_ph ? a_t_o :
             !end_addr ? (down ? a_t_o - ONE : a_t_o + ONE) :
             (elem_n == 3'd3 || elem_n == 3'd4) ? LAST : '0;
    rd_n = (elem_n != 3'd0 && elem_n != 3'd5) ? !ph_n : elem_n == 3'd5;
    miscmp = pv && q_t_i != pexp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bist_o <= 1'b0;
      csn_t_o <= 1'b1;
      wen_t_o <= 1'b1;
      a_t_o <= '0;
      d_t_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      fail_o <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      err_cnt_o <= '0;
      elem <= '0;
      ph <= 1'b0;
      pv <= 1'b0;
      pexp <= '0;
      paddr <= '0;
      pelem <= '0;
    end else begin
      csn_t_o <= 1'b1;
      wen_t_o <= 1'b1;
      a_t_o <= '0;
      d_t_o <= '0;
      pv <= !csn_t_o && wen_t_o && !abort_i;
      pexp <= elem[0] ? '0 : '1;
      paddr <= a_t_o;
      pelem <= elem;
      if (miscmp) begin
        err_cnt_o <= err_cnt_o + 8'(err_cnt_o != 8'hFF);
        fail_o <= 1'b1;
        if (!fail_o) begin
          fail_addr_o <= paddr;
          fail_elem_o <= pelem;
        end
      end
      case (state)
        IDLE, DONE: if (start_i) begin
          state <= SETUP;
          bist_o <= 1'b1;
          busy_o <= 1'b1;
          done_o <= 1'b0;
          fail_o <= 1'b0;
          fail_addr_o <= '0;
          fail_elem_o <= '0;
          err_cnt_o <= '0;
        end
        SETUP: if (abort_i) begin
          state <= IDLE;
          bist_o <= 1'b0;
          busy_o <= 1'b0;
        end else begin
          state <= RUN;
          csn_t_o <= 1'b0;
          wen_t_o <= 1'b0;
          elem <= '0;
          ph <= 1'b0;
        end
        RUN: if (abort_i) begin
          state <= IDLE;
          bist_o <= 1'b0;
          busy_o <= 1'b0;
        end else if (STOP_ON_FAIL && miscmp) begin
          state <= DONE;
          bist_o <= 1'b0;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else if (final_op) begin
          state <= DRAIN;
        end else begin
          csn_t_o <= 1'b0;
          wen_t_o <= rd_n;
          a_t_o <= addr_n;
          d_t_o <= rd_n ? '0 : {DATA_WIDTH{elem_n[0]}};
          elem <= elem_n;
          ph <= ph_n;
        end
        DRAIN: begin
          state <= abort_i ? IDLE : DONE;
          bist_o <= 1'b0;
          busy_o <= 1'b0;
          done_o <= !abort_i;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// tb_regfile_mbist_ctrl: scoreboard bench with behavioural register files, one DUT per STOP_ON_FAIL setting.
module tb_regfile_mbist_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, fault = 1'b0;
  logic bist0, csn0, wen0, busy0, done0, fail0, bist1, csn1, wen1, busy1, done1, fail1;
  logic [4:0] a0, fa0, a1, fa1;
  logic [31:0] d0, q0, d1, q1;
  logic [2:0] fe0, fe1;
  logic [7:0] err0, err1;
  int checks = 0, passes = 0, cyc = 0, t0 = 0, ops0 = 0, ops1 = 0, bad = 0;
  int done0_at = -1, done1_at = -1;
  logic [37:0] sbq[$];
  logic [37:0] log0[150];
  logic [31:0] mem0[16], mem1[16];
  localparam logic [63:0] RST_V = 64'({1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 8'd0});

  always #5 clk = ~clk;

  regfile_mbist_ctrl #(.STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .bist_o(bist0), .csn_t_o(csn0),
    .wen_t_o(wen0), .a_t_o(a0), .d_t_o(d0), .q_t_i(q0), .busy_o(busy0), .done_o(done0),
    .fail_o(fail0), .fail_addr_o(fa0), .fail_elem_o(fe0), .err_cnt_o(err0));
  regfile_mbist_ctrl #(.STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .bist_o(bist1), .csn_t_o(csn1),
    .wen_t_o(wen1), .a_t_o(a1), .d_t_o(d1), .q_t_i(q1), .busy_o(busy1), .done_o(done1),
    .fail_o(fail1), .fail_addr_o(fa1), .fail_elem_o(fe1), .err_cnt_o(err1));

  function automatic logic [31:0] rf_rd(input logic [31:0] v, input logic [4:0] a);
    return (fault && a == 5'd3) ? v | 32'h80 : v;
  endfunction

  always @(posedge clk) if (!csn0) begin
    if (!wen0) mem0[a0[3:0]] <= d0;
    else q0 <= rf_rd(mem0[a0[3:0]], a0);
  end
  always @(posedge clk) if (!csn1) begin
    if (!wen1) mem1[a1[3:0]] <= d1;
    else q1 <= rf_rd(mem1[a1[3:0]], a1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] outs0();
    return 64'({bist0, csn0, wen0, a0, d0, busy0, done0, fail0, fa0, fe0, err0});
  endfunction

  // expected port ops as {wen, a, d}; reads carry d=0
  task automatic push_march();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < 15; k++) begin
        logic [4:0] a = 5'((e == 3 || e == 4) ? 14 - k : k);
        logic [31:0] wd = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
        if (e != 0) sbq.push_back({1'b1, a, 32'h0});
        if (e != 5) sbq.push_back({1'b0, a, wd});
      end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!csn0) begin
      logic [37:0] got = {wen0, a0, d0};
      if (ops0 < 150) log0[ops0] = got;
      ops0++;
      if (a0 == 5'd15 || a0[4]) bad++;
      if (sbq.size() == 0) check("sb_empty", 64'(sbq.size()), 64'd1);
      else check("op", 64'(got), 64'(sbq.pop_front()));
    end
    if (!csn1) ops1++;
    if (done0 && done0_at < 0) done0_at = cyc;
    if (done1 && done1_at < 0) done1_at = cyc;
  endtask

  task automatic start_run();
    sbq.delete();
    push_march();
    ops0 = 0;
    ops1 = 0;
    bad = 0;
    done0_at = -1;
    done1_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    while (done0_at < 0 && cyc - t0 < 300) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset", outs0(), RST_V);
    rst = 1'b0;
    tick();
    check("idle_bist", 64'(bist0), 64'd0);
    start_run();
    check("setup", 64'({bist0, csn0, busy0}), 64'(3'b111));
    wait_done();
    check("done_lat", 64'(done0_at - t0 + 1), 64'd153);
    check("done_lat1", 64'(done1_at - t0 + 1), 64'd153);
    check("ops", 64'(ops0), 64'd150);
    check("fail_err", 64'({fail0, err0}), 64'd0);
    check("bad_addr", 64'(bad), 64'd0);
    check("done_state", 64'({done0, busy0, bist0, csn0}), 64'(4'b1001));
    check("e3_first", 64'(log0[75]), 64'({1'b1, 5'd14, 32'h0}));
    check("e3_last", 64'(log0[104]), 64'({1'b0, 5'd0, 32'hFFFF_FFFF}));
    check("e5_last", 64'(log0[149]), 64'({1'b1, 5'd14, 32'h0}));
    fault = 1'b1;
    start_run();
    wait_done();
    fault = 1'b0;
    check("flt_lat", 64'(done0_at - t0 + 1), 64'd153);
    check("flt_fail", 64'({done0, fail0, fa0, fe0}), 64'({1'b1, 1'b1, 5'd3, 3'd1}));
    check("flt_err", 64'(err0), 64'd3);
    check("sof_lat", 64'(done1_at - t0 + 1), 64'd25);
    check("sof_ops", 64'(ops1), 64'd23);
    check("sof_fail", 64'({done1, fail1, fa1, fe1}), 64'({1'b1, 1'b1, 5'd3, 3'd1}));
    check("sof_err", 64'(err1), 64'd1);
    start_run();
    while (ops0 < 40 && cyc - t0 < 300) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ops", 64'(ops0), 64'd40);
    check("abort_state", 64'({bist0, csn0, done0, busy0}), 64'(4'b0100));
    start_run();
    while (ops0 < 20 && cyc - t0 < 300) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("rerun_ops", 64'(ops0), 64'd150);
    check("rerun_lat", 64'(done0_at - t0 + 1), 64'd153);
    check("rerun_err", 64'({fail0, err0}), 64'd0);
    start_run();
    while (ops0 < 60 && cyc - t0 < 300) tick();
    rst = 1'b1;
    tick();
    check("rst_mid", outs0(), RST_V);
    check("rst_bist1", 64'({bist1, done1}), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_idle", 64'({busy0, done0, csn0}), 64'(3'b001));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
